// File: rtl/mem_bus2_pkg.sv
// ============================================================================
// Module      : mem_bus2_pkg
// Description : Shared types, default widths and helpers for the bus2 memory
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus2_pkg;

    localparam int DEF_LINE_ADDR_W = 14;
    localparam int DEF_DATA2_W     = 16;
    localparam int DEF_LINE_BYTES  = 16;
    localparam int DEF_MEM_LATENCY = 100;

    typedef enum logic [1:0] {
        NOP        = 2'd0,
        RESPONSE   = 2'd1,
        READ_LINE  = 2'd2,
        WRITE_LINE = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BEATS = 3'd1,
        RD_FETCH = 3'd2,
        WAIT     = 3'd3,
        RESP     = 3'd4
    } ctrl_state_e;

    function automatic int beats_of(input int line_bytes, input int data_w);
        return (line_bytes * 8) / data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus2_line_buf.sv
// ============================================================================
// Module      : mem_bus2_line_buf
// Description : BEATS x DATA2_W register file holding one fetched cache line;
//               one indexed fill port, one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus2_line_buf #(
    parameter  int BEATS   = 8,
    parameter  int DATA2_W = 16,
    localparam int BEAT_W  = $clog2(BEATS)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_fill_we,
    input  logic [BEAT_W-1:0]  i_fill_idx,
    input  logic [DATA2_W-1:0] i_fill_data,
    input  logic [BEAT_W-1:0]  i_rd_idx,
    output logic [DATA2_W-1:0] o_rd_data
);

    logic [DATA2_W-1:0] r_word [BEATS];

    for (genvar g = 0; g < BEATS; g++) begin : g_word
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                r_word[g] <= '0;
            end else if (i_fill_we && (i_fill_idx == BEAT_W'(g))) begin
                r_word[g] <= i_fill_data;
            end
        end
    end

    assign o_rd_data = r_word[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/mem_bus2_ctrl.sv
// ============================================================================
// Module      : mem_bus2_ctrl
// Description : Memory-side bus2 sequencer: line read/write with fixed latency
//               over a word-addressed synchronous SRAM. Optional statistics
//               counters enabled by macro MEM_BUS2_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus2_ctrl
    import mem_bus2_pkg::*;
#(
    parameter  int LINE_ADDR_W = DEF_LINE_ADDR_W,
    parameter  int DATA2_W     = DEF_DATA2_W,
    parameter  int LINE_BYTES  = DEF_LINE_BYTES,
    parameter  int MEM_LATENCY = DEF_MEM_LATENCY,
    localparam int BEATS       = beats_of(LINE_BYTES, DATA2_W),
    localparam int BEAT_W      = $clog2(BEATS)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [1:0]                    c2_cmd_i,
    input  logic [LINE_ADDR_W-1:0]        a2_i,
    input  logic [DATA2_W-1:0]            d2_i,
    output logic [1:0]                    c2_cmd_o,
    output logic [DATA2_W-1:0]            d2_o,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [LINE_ADDR_W+BEAT_W-1:0] mem_addr_o,
    output logic                          mem_we_o,
    output logic [DATA2_W-1:0]            mem_wdata_o,
    input  logic [DATA2_W-1:0]            mem_rdata_i,
    output logic [15:0]                   rd_count_o,
    output logic [15:0]                   wr_count_o
);

    localparam int                LAT_W      = $clog2(MEM_LATENCY);
    // Loaded in the accept cycle so the counter reads zero in cycle T+MEM_LATENCY-1.
    localparam logic [LAT_W-1:0]  c_LAT_LOAD = LAT_W'(MEM_LATENCY - 2);
    localparam logic [BEAT_W-1:0] c_LAST     = BEAT_W'(BEATS - 1);

    if ((MEM_LATENCY < BEATS + 2) || (BEATS < 2)) begin : g_bad_cfg
        $error("mem_bus2_ctrl: MEM_LATENCY must be >= BEATS+2 and BEATS >= 2");
    end

    ctrl_state_e                   r_state;
    c2_cmd_e                       r_c2_cmd;
    logic                          r_is_read;
    logic [LINE_ADDR_W-1:0]        r_line;
    logic [BEAT_W-1:0]             r_beat;
    logic [LAT_W-1:0]              r_lat;
    logic [DATA2_W-1:0]            r_d2;
    logic                          r_busy;
    logic                          r_err;
    logic                          r_we;
    logic [LINE_ADDR_W+BEAT_W-1:0] r_addr;
    logic [DATA2_W-1:0]            r_wdata;
    logic                          r_rd_issue;
    logic                          r_rd_vld;
    logic [BEAT_W-1:0]             r_rd_idx;

    c2_cmd_e             w_cmd;
    logic                w_last_beat;
    logic                w_resp_done;
    logic [BEAT_W-1:0]   w_buf_ridx;
    logic [DATA2_W-1:0]  w_buf_rdata;

    assign w_cmd       = c2_cmd_e'(c2_cmd_i);
    assign w_last_beat = (r_beat == c_LAST);
    assign w_resp_done = (r_state == RESP) && (!r_is_read || w_last_beat);
    // Look one beat ahead so d2_o can be registered.
    assign w_buf_ridx  = (r_state == RESP) ? r_beat + BEAT_W'(1) : '0;

    mem_bus2_line_buf #(
        .BEATS   (BEATS),
        .DATA2_W (DATA2_W)
    ) u_line_buf (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_fill_we   (r_rd_vld),
        .i_fill_idx  (r_rd_idx),
        .i_fill_data (mem_rdata_i),
        .i_rd_idx    (w_buf_ridx),
        .o_rd_data   (w_buf_rdata)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_c2_cmd   <= NOP;
            r_is_read  <= 1'b0;
            r_line     <= '0;
            r_beat     <= '0;
            r_lat      <= '0;
            r_d2       <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_issue <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_idx   <= '0;
        end else begin
            r_rd_vld <= r_rd_issue;
            r_rd_idx <= r_addr[BEAT_W-1:0];
            if ((r_state != IDLE) && (r_lat != '0)) begin
                r_lat <= r_lat - LAT_W'(1);
            end
            if ((r_state != IDLE) && (w_cmd != NOP)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_cmd == RESPONSE) begin
                        r_err <= 1'b1;
                    end else if ((w_cmd == READ_LINE) || (w_cmd == WRITE_LINE)) begin
                        r_line     <= a2_i;
                        r_is_read  <= (w_cmd == READ_LINE);
                        r_beat     <= BEAT_W'(1);
                        r_lat      <= c_LAT_LOAD;
                        r_busy     <= 1'b1;
                        r_addr     <= {a2_i, BEAT_W'(0)};
                        r_we       <= (w_cmd == WRITE_LINE);
                        r_rd_issue <= (w_cmd == READ_LINE);
                        if (w_cmd == WRITE_LINE) begin
                            r_wdata <= d2_i;
                        end
                        r_state    <= (w_cmd == READ_LINE) ? RD_FETCH : WR_BEATS;
                    end
                end
                WR_BEATS, RD_FETCH: begin
                    r_addr <= {r_line, r_beat};
                    if (r_state == WR_BEATS) begin
                        r_we    <= 1'b1;
                        r_wdata <= d2_i;
                    end else begin
                        r_rd_issue <= 1'b1;
                    end
                    if (w_last_beat) begin
                        r_state <= WAIT;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                WAIT: begin
                    r_we       <= 1'b0;
                    r_rd_issue <= 1'b0;
                    if (r_lat == '0) begin
                        r_state  <= RESP;
                        r_c2_cmd <= RESPONSE;
                        r_beat   <= '0;
                        r_d2     <= r_is_read ? w_buf_rdata : '0;
                    end
                end
                RESP: begin
                    if (w_resp_done) begin
                        r_state  <= IDLE;
                        r_c2_cmd <= NOP;
                        r_d2     <= '0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                        r_d2   <= w_buf_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign c2_cmd_o    = r_c2_cmd;
    assign d2_o        = r_d2;
    assign busy_o      = r_busy;
    assign err_o       = r_err;
    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_wdata_o = r_wdata;

`ifdef MEM_BUS2_CTRL_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_resp_done) begin
            if (r_is_read) begin
                if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            end else begin
                if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign rd_count_o = r_rd_count;
    assign wr_count_o = r_wr_count;
`else
    assign rd_count_o = '0;
    assign wr_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/mem_bus2_ctrl.md
Name: mem_bus2_ctrl

Overview:
- Memory-side sequencer for the cache-to-memory bus (bus2). Accepts line-granular READ_LINE and WRITE_LINE commands from the cache controller.
- Enforces the fixed memory access latency and moves a cache line in little-endian DATA2-wide beats. Signals completion with RESPONSE.
- Drives a synchronous single-port backing store through a word-addressed SRAM interface.
- Bus2 is split into separate in/out signals; any tristate merging is done at top level.

Parameters:
- LINE_ADDR_W, 14, line address width (tag+set bits)
- DATA2_W, 16, bus2 data width in bits; multiple of 8
- LINE_BYTES, 16, cache line size in bytes
- MEM_LATENCY, 100, cycles from command cycle to first RESPONSE cycle; elaboration error if < BEATS+2
- Derived: BEATS = LINE_BYTES*8/DATA2_W (default 8); BEAT_W = clog2(BEATS)

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- c2_cmd_i  in  2  cache command: 0 NOP, 1 RESPONSE (illegal from cache), 2 READ_LINE, 3 WRITE_LINE
- a2_i  in  LINE_ADDR_W  line address; sampled only in the command cycle
- d2_i  in  DATA2_W  write beats
- c2_cmd_o  out  2  NOP(0) or RESPONSE(1)
- d2_o  out  DATA2_W  read beats; 0 when not responding
- busy_o  out  1  high from the cycle after acceptance until the last RESPONSE cycle, inclusive
- err_o  out  1  sticky; set on any command while busy, or on c2_cmd_i=RESPONSE
- mem_addr_o  out  LINE_ADDR_W+BEAT_W  {line, beat}
- mem_we_o  out  1  write strobe
- mem_wdata_o  out  DATA2_W  write word
- mem_rdata_i  in  DATA2_W  read word, valid 1 cycle after address
- rd_count_o, wr_count_o  out  16 each  statistics (see Optional Feature)

Behaviour:
- Reset values: state IDLE; c2_cmd_o=NOP; d2_o=0; busy_o=0; err_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; counters=0.
- Timing reference: T = command-accept cycle, IDLE with cmd 2/3.
- IDLE:
  - cmd NOP: stay.
  - cmd 1: set err_o, stay.
  - WRITE_LINE: latch a2_i, capture beat 0 from d2_i in cycle T -> WR_BEATS.
  - READ_LINE: latch a2_i -> RD_FETCH.
- WR_BEATS:
  - Beat k (k=0..BEATS-1) is present on d2_i in cycle T+k.
  - Each beat is written to the store one cycle after capture: mem_we_o=1, addr {line,k}.
  - After the last beat -> WAIT.
- RD_FETCH:
  - Issues BEATS consecutive reads, addr {line,0..BEATS-1}.
  - Stores mem_rdata_i into an internal line buffer one cycle later.
  - Then -> WAIT.
- WAIT:
  - A down-counter ensures the first RESPONSE cycle is exactly T+MEM_LATENCY for both commands.
  - -> RESP.
- RESP, write: c2_cmd_o=RESPONSE for exactly 1 cycle; d2_o=0; -> IDLE.
- RESP, read:
  - c2_cmd_o=RESPONSE for BEATS consecutive cycles; beat k on d2_o in cycle T+MEM_LATENCY+k.
  - Beat k = {byte 2k+1, byte 2k} for DATA2_W=16 (little-endian, lower byte in [7:0]).
  - -> IDLE.
- Back-to-back: a new command is accepted in the first cycle after the last RESPONSE cycle (busy_o=0).
- Any command (2/3/1) while busy_o=1: ignored, err_o set; the current transfer is unaffected.
- err_o clears only on RESET.
- RESET mid-operation:
  - Immediate abort; all outputs go to reset values asynchronously.
  - Store writes already issued remain (partial line permitted); no further writes.
- Address wrap: none; mem_addr_o beat field never exceeds BEATS-1.

Optional Feature:
- Macro MEM_BUS2_CTRL_STATS_EN.
- Defined:
  - rd_count_o increments on each completed read (last RESPONSE beat).
  - wr_count_o increments on each completed write RESPONSE.
  - Both saturate at 16'hFFFF and clear on RESET.
- Undefined: both ports are constant 0 and no counter flops exist.

Decomposition:
- Shared package mem_bus2_pkg:
  - c2_cmd_e enum (NOP, RESPONSE, READ_LINE, WRITE_LINE)
  - ctrl_state_e (IDLE, WR_BEATS, RD_FETCH, WAIT, RESP)
  - default widths LINE_ADDR_W, DATA2_W, LINE_BYTES, MEM_LATENCY
  - function beats_of()
- One sub-module: mem_bus2_line_buf, a BEATS x DATA2_W register file with a write port (fill) and a read port (response beat index).

Test Plan (MEM_LATENCY=12, BEATS=8):
- WRITE_LINE a2=0x0A5, beats 0x0100..0x0807 on cycles T..T+7 -> store words {0x0A5,0..7} hold those values; single RESPONSE at T+12; busy_o low at T+13.
- Preload store line 0x003 bytes 0x00..0x0F, READ_LINE at T -> RESPONSE T+12..T+19; d2_o 0x0100, 0x0302, ..., 0x0F0E.
- READ_LINE at T, WRITE_LINE at T+5 -> err_o=1 from T+6; read response is unchanged; no store write for the second command.
- RESET asserted at T+3 of a write -> all outputs 0 immediately; store holds only beats 0..1; a new READ_LINE is accepted after release.
- Write then read of the same line back-to-back (second command in the first non-busy cycle) -> read returns the written data.
- STATS_EN defined: 3 writes + 2 reads -> wr_count_o=3, rd_count_o=2. Undefined: both ports read 0.
